// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   VGA raster timing generator for the 25 MHz pixel clock domain. A stage-0
//   pair of counters walks the raster; a stage-1 register bank presents the
//   pixel coordinates, video_on and the line/frame strobes to the colour
//   renderer. Sync pulses are registered in stage 1 and then delayed by
//   PIPE_DELAY further cycles, so that they line up with the renderer's
//   registered colour outputs.
//
// Ports
//   clk_0        in   1  pixel clock (single clock domain)
//   rst          in   1  asynchronous, active-low reset
//   enable       in   1  advance one pixel per clock when 1, hold when 0
//   pixel_x      out 10  horizontal position, 0..H_TOTAL-1
//   pixel_y      out 10  vertical position, 0..V_TOTAL-1
//   video_on     out  1  inside the visible area
//   hsync        out  1  horizontal sync, active level SYNC_POL
//   vsync        out  1  vertical sync, active level SYNC_POL
//   line_start   out  1  one-cycle strobe on the first pixel of a line
//   frame_start  out  1  one-cycle strobe on the first pixel of a frame
//   frame_count  out  8  completed-frame counter (wraps 255 -> 0)
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int   H_VIDEO    = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_VIDEO    = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 1
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VIDEO + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIDEO + V_FRONT + V_SYNC + V_BACK;

  // Raster totals must fit the 10-bit counters; the delay line is 0..4 deep.
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_total_check
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if ((PIPE_DELAY < 0) || (PIPE_DELAY > 4)) begin : g_delay_check
    $error("vga_sync_gen: PIPE_DELAY must be in 0..4");
  end

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  // Bounds are kept 11 bits wide so a full 1024-pixel value still compares.
  localparam logic [10:0] H_VIDEO_L  = 11'(H_VIDEO);
  localparam logic [10:0] V_VIDEO_L  = 11'(V_VIDEO);
  localparam logic [10:0] HS_FIRST_L = 11'(H_VIDEO + H_FRONT);
  localparam logic [10:0] HS_LAST_L  = 11'(H_VIDEO + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST_L = 11'(V_VIDEO + V_FRONT);
  localparam logic [10:0] VS_LAST_L  = 11'(V_VIDEO + V_FRONT + V_SYNC - 1);

  // Stage 0 state
  logic [9:0] h_cnt_r;
  logic [9:0] v_cnt_r;
  logic [7:0] frame_count_r;

  // Stage 0 decode
  logic [10:0] h_ext_s;
  logic [10:0] v_ext_s;
  logic        h_last_s;
  logic        v_last_s;
  logic        hs_active_s;
  logic        vs_active_s;
  logic        hs_raw_s;
  logic        vs_raw_s;

  // Stage 1 registers
  logic [9:0] pixel_x_r;
  logic [9:0] pixel_y_r;
  logic       video_on_r;
  logic       line_start_r;
  logic       frame_start_r;
  logic       hs1_r;
  logic       vs1_r;

  assign h_ext_s     = {1'b0, h_cnt_r};
  assign v_ext_s     = {1'b0, v_cnt_r};
  assign h_last_s    = (h_cnt_r == H_LAST);
  assign v_last_s    = (v_cnt_r == V_LAST);
  assign hs_active_s = (h_ext_s >= HS_FIRST_L) && (h_ext_s <= HS_LAST_L);
  assign vs_active_s = (v_ext_s >= VS_FIRST_L) && (v_ext_s <= VS_LAST_L);
  assign hs_raw_s    = hs_active_s ? SYNC_POL : ~SYNC_POL;
  assign vs_raw_s    = vs_active_s ? SYNC_POL : ~SYNC_POL;

  // Stage 0: raster counters and completed-frame counter, advanced by enable.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      h_cnt_r       <= 10'd0;
      v_cnt_r       <= 10'd0;
      frame_count_r <= 8'd0;
    end else if (enable) begin
      if (h_last_s) begin
        h_cnt_r <= 10'd0;
        if (v_last_s) begin
          v_cnt_r       <= 10'd0;
          frame_count_r <= frame_count_r + 8'd1;
        end else begin
          v_cnt_r <= v_cnt_r + 10'd1;
        end
      end else begin
        h_cnt_r <= h_cnt_r + 10'd1;
      end
    end
  end

  // Stage 1: presentation registers, reloaded from stage 0 every clock.
  // Strobes are qualified by enable so a stall on pixel 0 cannot repeat them.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      pixel_x_r     <= 10'd0;
      pixel_y_r     <= 10'd0;
      video_on_r    <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      hs1_r         <= ~SYNC_POL;
      vs1_r         <= ~SYNC_POL;
    end else begin
      pixel_x_r     <= h_cnt_r;
      pixel_y_r     <= v_cnt_r;
      video_on_r    <= (h_ext_s < H_VIDEO_L) && (v_ext_s < V_VIDEO_L);
      line_start_r  <= enable && (h_cnt_r == 10'd0);
      frame_start_r <= enable && (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
      hs1_r         <= hs_raw_s;
      vs1_r         <= vs_raw_s;
    end
  end

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign hsync = hs1_r;
    assign vsync = vs1_r;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] hs_dly_r;
    logic [PIPE_DELAY-1:0] vs_dly_r;

    // Sync alignment shift register; free-running, independent of enable.
    always_ff @(posedge clk_0 or negedge rst) begin
      if (!rst) begin
        hs_dly_r <= {PIPE_DELAY{~SYNC_POL}};
        vs_dly_r <= {PIPE_DELAY{~SYNC_POL}};
      end else begin
        hs_dly_r[0] <= hs1_r;
        vs_dly_r[0] <= vs1_r;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          hs_dly_r[i] <= hs_dly_r[i-1];
          vs_dly_r[i] <= vs_dly_r[i-1];
        end
      end
    end

    assign hsync = hs_dly_r[PIPE_DELAY-1];
    assign vsync = vs_dly_r[PIPE_DELAY-1];
  end

  assign pixel_x     = pixel_x_r;
  assign pixel_y     = pixel_y_r;
  assign video_on    = video_on_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  // frame_count comes from stage 0, so it steps on the edge that presents the
  // last pixel of a frame, one cycle ahead of the next frame_start.
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Two instances: "a" uses the default 640x480 timing (PIPE_DELAY=1,
//   active-low syncs); "b" uses a 16x10 raster (visible 8x6, active-high syncs,
//   PIPE_DELAY=2) so that whole frames and the 255->0 frame-count wrap fit in a
//   short run. Stimulus processes push hand-derived expectations, stamped with
//   the cycle they apply to, into per-instance queues; a monitor samples the
//   outputs on every falling edge and retires due expectations.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int S_X = 0, S_Y = 1, S_VO = 2, S_HS = 3, S_VS = 4;
  localparam int S_LS = 5, S_FS = 6, S_FC = 7;

  typedef struct {
    int at;
    int sel;
    int val;
  } exp_t;

  logic clk_0;
  logic rst_a, en_a, rst_b, en_b;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_vo, a_hs, a_vs, a_ls, a_fs, b_vo, b_hs, b_vs, b_ls, b_fs;
  logic [7:0] a_fc, b_fc;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  vga_sync_gen dut_a (
    .clk_0(clk_0), .rst(rst_a), .enable(en_a),
    .pixel_x(a_x), .pixel_y(a_y), .video_on(a_vo),
    .hsync(a_hs), .vsync(a_vs), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_sync_gen #(
    .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VIDEO(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b1), .PIPE_DELAY(2)
  ) dut_b (
    .clk_0(clk_0), .rst(rst_b), .enable(en_b),
    .pixel_x(b_x), .pixel_y(b_y), .video_on(b_vo),
    .hsync(b_hs), .vsync(b_vs), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  always @(posedge clk_0) cyc <= cyc + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      S_X:     return "pixel_x";
      S_Y:     return "pixel_y";
      S_VO:    return "video_on";
      S_HS:    return "hsync";
      S_VS:    return "vsync";
      S_LS:    return "line_start";
      S_FS:    return "frame_start";
      S_FC:    return "frame_count";
      default: return "unknown";
    endcase
  endfunction

  function automatic int sample(input bit inst, input int sel);
    if (!inst) begin
      case (sel)
        S_X:     return int'(a_x);
        S_Y:     return int'(a_y);
        S_VO:    return int'(a_vo);
        S_HS:    return int'(a_hs);
        S_VS:    return int'(a_vs);
        S_LS:    return int'(a_ls);
        S_FS:    return int'(a_fs);
        S_FC:    return int'(a_fc);
        default: return -1;
      endcase
    end else begin
      case (sel)
        S_X:     return int'(b_x);
        S_Y:     return int'(b_y);
        S_VO:    return int'(b_vo);
        S_HS:    return int'(b_hs);
        S_VS:    return int'(b_vs);
        S_LS:    return int'(b_ls);
        S_FS:    return int'(b_fs);
        S_FC:    return int'(b_fc);
        default: return -1;
      endcase
    end
  endfunction

  task automatic compare_item(input bit inst, input exp_t e);
    int got;
    got = sample(inst, e.sel);
    n_cmp++;
    if (e.at != cyc) begin
      n_err++;
      $display("FAIL %s.%s late: due cycle %0d, checked at cycle %0d (got %0d, want %0d)",
               inst ? "b" : "a", sel_name(e.sel), e.at, cyc, got, e.val);
    end else if (got != e.val) begin
      n_err++;
      $display("FAIL %s.%s @cycle %0d: got %0d, want %0d",
               inst ? "b" : "a", sel_name(e.sel), cyc, got, e.val);
    end
  endtask

  // Monitor: retire every expectation that is due at this falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_0);
      while (qa.size() > 0 && qa[0].at <= cyc) begin
        e = qa.pop_front();
        compare_item(1'b0, e);
      end
      while (qb.size() > 0 && qb[0].at <= cyc) begin
        e = qb.pop_front();
        compare_item(1'b1, e);
      end
    end
  end

  task automatic push(input bit inst, input int at, input int sel, input int val);
    exp_t e;
    e.at = at;
    e.sel = sel;
    e.val = val;
    if (val >= 0) begin
      if (!inst) qa.push_back(e);
      else       qb.push_back(e);
    end
  endtask

  // A negative value means "don't check this field".
  task automatic expect_row(input bit inst, input int at, input int x, input int y,
                            input int vo, input int hs, input int vs, input int ls,
                            input int fs, input int fc);
    push(inst, at, S_X, x);
    push(inst, at, S_Y, y);
    push(inst, at, S_VO, vo);
    push(inst, at, S_HS, hs);
    push(inst, at, S_VS, vs);
    push(inst, at, S_LS, ls);
    push(inst, at, S_FS, fs);
    push(inst, at, S_FC, fc);
  endtask

  // Return 2 time units after the rising edge that makes cyc == c.
  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk_0);
      #2;
    end
  endtask

  // Instance a: 800x525 raster, active-low syncs, one cycle of sync delay.
  task automatic run_a();
    int b0, l2, c, x, y, u, hs;
    go_to(4);
    expect_row(1'b0, 4, 0, 0, 0, 1, 1, 0, 0, 0);
    rst_a = 1'b1;
    en_a  = 1'b1;
    b0 = 5;
    // Lines 0 and 1 free-running: hsync low for prior pixel_x in 656..751.
    for (int t = 0; t < 1600; t++) begin
      x = t % 800;
      y = t / 800;
      u = t - 1;
      hs = (u >= 0 && (u % 800) >= 656 && (u % 800) <= 751) ? 0 : 1;
      expect_row(1'b0, b0 + t, x, y, (x < 640) ? 1 : 0, hs, 1,
                 (x == 0) ? 1 : 0, (t == 0) ? 1 : 0, -1);
    end
    // Stall 37 cycles with line 2 pixel 0 presented.
    go_to(b0 + 1599);
    en_a = 1'b0;
    for (int k = b0 + 1600; k <= b0 + 1636; k++)
      expect_row(1'b0, k, 0, 2, 1, 1, 1, 0, 0, 0);
    go_to(b0 + 1636);
    en_a = 1'b1;
    l2 = b0 + 1637;
    for (int s = 0; s <= 800; s++) begin
      x = s % 800;
      y = 2 + s / 800;
      hs = (s >= 1 && (s - 1) >= 656 && (s - 1) <= 751) ? 0 : 1;
      expect_row(1'b0, l2 + s, x, y, (x < 640) ? 1 : 0, hs, 1,
                 (x == 0) ? 1 : 0, 0, -1);
    end
    // Asynchronous reset while line 100 is at pixel 300.
    c = l2 + 98 * 800 + 300;
    go_to(c - 2);
    expect_row(1'b0, c - 1, 299, 100, 1, 1, 1, 0, 0, 0);
    go_to(c);
    rst_a = 1'b0;
    expect_row(1'b0, c, 0, 0, 0, 1, 1, 0, 0, 0);
    go_to(c + 2);
    rst_a = 1'b1;
    expect_row(1'b0, c + 2, 0, 0, 0, 1, 1, 0, 0, 0);
    expect_row(1'b0, c + 3, 0, 0, 1, 1, 1, 1, 1, 0);
    expect_row(1'b0, c + 4, 1, 0, 1, 1, 1, 0, 0, 0);
    go_to(c + 5);
  endtask

  // Instance b: 16x10 raster, active-high syncs, two cycles of sync delay.
  task automatic run_b();
    int bb, c, x, y, u, hs, vs, k;
    int ks[4];
    ks = '{2, 100, 255, 256};
    go_to(6);
    expect_row(1'b1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_b = 1'b1;
    en_b  = 1'b1;
    bb = 7;
    // One full frame plus two cycles; hsync for x 10..12, vsync for y 7..8.
    for (int t = 0; t < 162; t++) begin
      x = t % 16;
      y = (t / 16) % 10;
      u = t - 2;
      hs = (u >= 0 && (u % 16) >= 10 && (u % 16) <= 12) ? 1 : 0;
      vs = (u >= 0 && ((u / 16) % 10) >= 7 && ((u / 16) % 10) <= 8) ? 1 : 0;
      expect_row(1'b1, bb + t, x, y, (x < 8 && y < 6) ? 1 : 0, hs, vs,
                 (x == 0) ? 1 : 0, (t % 160 == 0) ? 1 : 0, ((t + 1) / 160) % 256);
    end
    // Frame boundaries: frame_count steps on the last pixel of each frame.
    for (int i = 0; i < 4; i++) begin
      k = ks[i];
      push(1'b1, bb + k * 160 - 2, S_FC, (k - 1) % 256);
      push(1'b1, bb + k * 160 - 1, S_FC, k % 256);
      expect_row(1'b1, bb + k * 160, 0, 0, 1, -1, -1, 1, 1, k % 256);
    end
    // Reset while hsync is active and the delay line holds active levels.
    c = bb + 257 * 160 + 13;
    go_to(c - 2);
    expect_row(1'b1, c - 1, 12, 0, 0, 1, 0, 0, 0, 1);
    go_to(c);
    rst_b = 1'b0;
    expect_row(1'b1, c, 0, 0, 0, 0, 0, 0, 0, 0);
    go_to(c + 1);
    rst_b = 1'b1;
    expect_row(1'b1, c + 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_row(1'b1, c + 2, 0, 0, 1, 0, 0, 1, 1, 0);
    expect_row(1'b1, c + 3, 1, 0, 1, 0, 0, 0, 0, 0);
    go_to(c + 4);
  endtask

  initial begin
    rst_a = 1'b0;
    en_a  = 1'b0;
    rst_b = 1'b0;
    en_b  = 1'b0;
    fork
      run_a();
      run_b();
    join
    repeat (2) @(negedge clk_0);
    #1;
    while (qa.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL a.%s unchecked: due cycle %0d, want %0d",
               sel_name(qa[0].sel), qa[0].at, qa[0].val);
      void'(qa.pop_front());
    end
    while (qb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL b.%s unchecked: due cycle %0d, want %0d",
               sel_name(qb[0].sel), qb[0].at, qb[0].val);
      void'(qb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded 200000 cycles, got cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
